// File: rtl/me_pkg.sv
// Shared widths and mv_data field layout for the motion-estimation result path.
package me_pkg;

  localparam int MV_DATA_W   = 40;
  localparam int SAD_W       = 14;
  localparam int MV_W        = 4;
  localparam int BLK_COORD_W = 9;

  localparam int MV_X_LSB  = 0;
  localparam int MV_Y_LSB  = MV_X_LSB + MV_W;
  localparam int SAD_LSB   = MV_Y_LSB + MV_W;
  localparam int BLK_X_LSB = SAD_LSB + SAD_W;
  localparam int BLK_Y_LSB = BLK_X_LSB + BLK_COORD_W;

  function automatic logic [MV_DATA_W-1:0] pack_entry(
    input logic [BLK_COORD_W-1:0] blk_y,
    input logic [BLK_COORD_W-1:0] blk_x,
    input logic [SAD_W-1:0]       sad,
    input logic [MV_W-1:0]        mv_y,
    input logic [MV_W-1:0]        mv_x
  );
    logic [MV_DATA_W-1:0] d;
    d = '0;
    d[BLK_Y_LSB +: BLK_COORD_W] = blk_y;
    d[BLK_X_LSB +: BLK_COORD_W] = blk_x;
    d[SAD_LSB   +: SAD_W]       = sad;
    d[MV_Y_LSB  +: MV_W]        = mv_y;
    d[MV_X_LSB  +: MV_W]        = mv_x;
    return d;
  endfunction

endpackage

// File: rtl/me_sync_fifo.sv
// Single-clock FIFO; read data is zero while empty so the output is clean after reset.
module me_sync_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_ok, rd_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // A write into a full FIFO is legal when the head leaves in the same cycle.
  assign rd_ok = rd_en_i & ~empty_o;
  assign wr_ok = wr_en_i & (~full_o | rd_ok);

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/mv_collector.sv
// Tags per-block SAD/motion-vector results with raster block coordinates and
// queues them for a ready/valid consumer; drops (and flags) when the queue is full.
module mv_collector
  import me_pkg::*;
#(
  parameter int BLK_COLS   = 480,
  parameter int BLK_ROWS   = 270,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 sad_en,
  input  logic [SAD_W-1:0]     sad_min,
  input  logic [MV_W-1:0]      motion_vec_x_min,
  input  logic [MV_W-1:0]      motion_vec_y_min,
  output logic                 mv_valid,
  input  logic                 mv_ready,
  output logic [MV_DATA_W-1:0] mv_data,
  output logic                 frame_done,
  output logic                 overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BLK_COORD_W-1:0] LAST_X = BLK_COORD_W'(BLK_COLS - 1);
  localparam logic [BLK_COORD_W-1:0] LAST_Y = BLK_COORD_W'(BLK_ROWS - 1);

  logic [BLK_COORD_W-1:0] blk_x_q, blk_x_d;
  logic [BLK_COORD_W-1:0] blk_y_q, blk_y_d;
  logic                   frame_done_q, frame_done_d;
  logic                   overflow_q, overflow_d;

  logic [BLK_COORD_W-1:0] x_cur, y_cur;
  logic                   at_last_x, at_last_y;
  logic                   pop, push, drop;
  logic                   fifo_full, fifo_empty;
  logic [CNT_W-1:0]       fifo_count;
  logic [MV_DATA_W-1:0]   entry;

  // frame_start takes effect before a coincident sad_en is tagged.
  assign x_cur     = frame_start ? '0 : blk_x_q;
  assign y_cur     = frame_start ? '0 : blk_y_q;
  assign at_last_x = (x_cur == LAST_X);
  assign at_last_y = (y_cur == LAST_Y);

  assign mv_valid = ~fifo_empty;
  assign pop      = mv_valid & mv_ready;
  assign push     = sad_en & (~fifo_full | pop);
  assign drop     = sad_en & fifo_full & ~pop;

  assign entry = pack_entry(y_cur, x_cur, sad_min, motion_vec_y_min, motion_vec_x_min);

  always_comb begin
    blk_x_d      = x_cur;
    blk_y_d      = y_cur;
    frame_done_d = 1'b0;
    if (sad_en) begin
      frame_done_d = at_last_x & at_last_y;
      if (at_last_x) begin
        blk_x_d = '0;
        blk_y_d = at_last_y ? '0 : y_cur + 1'b1;
      end else begin
        blk_x_d = x_cur + 1'b1;
      end
    end
    // A drop in the same cycle as frame_start still leaves overflow set.
    overflow_d = drop | (overflow_q & ~frame_start);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_x_q      <= '0;
      blk_y_q      <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      blk_x_q      <= blk_x_d;
      blk_y_q      <= blk_y_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

  me_sync_fifo #(
    .WIDTH (MV_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (push),
    .wr_data_i (entry),
    .rd_en_i   (pop),
    .rd_data_o (mv_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    fifo_count <= CNT_W'(FIFO_DEPTH));

endmodule
